motor_pwm_capture: RTL and testbench
====================================

Name: motor_pwm_capture

Overview:
- Receive-side counterpart to motor_control. Samples the four PWM drive lines (fwd/rev, left/right) and reconstructs the signed 11-bit duty commands that produced them.
- Used for closed-loop self-check of the PWM peripheral and for the line-follower's diagnostic readback path.
- Flags shoot-through, i.e. fwd and rev of the same side high simultaneously.

Parameters:
- PERIOD, 1024, PWM frame length in clk cycles. Must equal the motor_control PWM period. Legal range 4..1024.
- SYNC_STAGES, 2, flops in the input synchronizer chain on each PWM line. Legal range 2..3.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- fwd_lft  input  1  left forward PWM line (asynchronous to clk)
- rev_lft  input  1  left reverse PWM line
- fwd_rht  input  1  right forward PWM line
- rev_rht  input  1  right reverse PWM line
- clr_err  input  1  clears both shoot-through sticky flags
- lft_meas  output  11  signed reconstructed left command, two's complement
- rht_meas  output  11  signed reconstructed right command
- meas_vld  output  1  one-cycle pulse; lft_meas/rht_meas updated this cycle
- shoot_lft  output  1  sticky: fwd_lft and rev_lft seen high together
- shoot_rht  output  1  sticky: fwd_rht and rev_rht seen high together

Behaviour:
- Reset, applied asynchronously:
  - All synchronizer flops, counters and the window counter go to 0.
  - lft_meas=0, rht_meas=0, meas_vld=0, shoot_lft=0, shoot_rht=0.
- Synchronizer: each input passes through SYNC_STAGES flops. All logic below uses only the synchronized signals.
- Window counter: free-running, 0..PERIOD-1, wraps to 0. It has no alignment to the PWM source. A window of exactly PERIOD cycles counts a periodic PWM's high time exactly, independent of phase.
- Per-line high counters: four counters, each 11 bits internally.
  - A counter increments on every cycle its synchronized line is 1.
  - On the cycle the window counter equals PERIOD-1, each counter loads 0, or 1 if its line is high that cycle. The next window starts with no lost cycle.
- Magnitude clamp: a window count greater than 1023 is clamped to 1023. This only occurs with PERIOD=1024 and a line continuously high.
- Result:
  - On the cycle after the window counter wraps, lft_meas = clamp(fwd_lft count) - clamp(rev_lft count), computed as an 11-bit signed subtraction. The range -1023..1023 cannot overflow.
  - rht_meas is computed the same way from the right-side counts.
  - meas_vld=1 for exactly that one cycle.
- Outputs hold between pulses.
- Latency: an input edge reaches the counters after SYNC_STAGES cycles. The first meas_vld after reset deassertion occurs PERIOD+1 cycles later. Steady-state meas_vld period is exactly PERIOD.
- Shoot-through:
  - If synchronized fwd_x and rev_x are both 1 in any cycle, shoot_x sets and stays set.
  - Both counters still increment in that cycle, so the overlap contributes net zero to x_meas.
  - clr_err clears both flags on the next edge. If set and clear occur in the same cycle, set wins.
- Boundary cases:
  - Both lines low all window gives meas 0.
  - A command changing mid-window gives a blended value for that one window. The next full window is exact.
  - Reset asserted mid-window discards the partial window; no meas_vld is issued for it.
  - clr_err while already clear has no effect.

Decomposition:
- Package motor_pwm_pkg:
  - CMD_W=11 (signed command width)
  - MAG_MAX=1023
  - default PERIOD
  - a signed 11-bit command typedef, shared with motor_control
- One natural sub-module, pwm_high_counter: synchronizer plus windowed high-cycle counter with clamp for a single line. Instantiate it 4 times.
- Top level holds: the window counter, the two subtractors, the meas_vld register and the shoot-through flags.

Test Plan:
- motor_control driven with lft=100, rht=-102 into the capture block -> from the second meas_vld onward, lft_meas=100 and rht_meas=-102 on every pulse.
- lft=0, rht=0 -> lft_meas=0, rht_meas=0, no shoot flags; meas_vld pulses every 1024 cycles.
- lft=1023, rht=-1023 -> 1023/-1023. Then force fwd_lft constantly high -> lft_meas clamps at 1023 with no wrap to negative.
- Force fwd_rht=rev_rht=1 for 3 cycles -> shoot_rht=1 and stays set, shoot_lft=0. Pulse clr_err -> shoot_rht=0. Re-overlap in the same cycle as clr_err -> stays 1.
- Assert rst_n=0 mid-window (window count about 500) -> all outputs 0 immediately with no clk needed. After release, the first meas_vld arrives exactly PERIOD+1 cycles later with a correct value.
- Change lft from 100 to 300 mid-window -> one intermediate value in (100,300), then 300 on the following pulse.

Source files
------------

// File: rtl/motor_pwm_pkg.sv
// Shared types and constants for the motor PWM drive and capture blocks.
package motor_pwm_pkg;

    localparam int CMD_W      = 11;
    localparam int PERIOD_DEF = 1024;
    localparam int SYNC_DEF   = 2;

    localparam logic [CMD_W-1:0] MAG_MAX = 11'd1023;

    typedef logic signed [CMD_W-1:0] cmd_t;

    // A line held high for a whole 1024-cycle window counts 1024, one above the
    // largest representable command magnitude.
    function automatic logic [CMD_W-1:0] clamp_mag(input logic [CMD_W-1:0] cnt);
        logic [CMD_W-1:0] res;
        if (cnt > MAG_MAX) begin
            res = MAG_MAX;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/motor_pwm_capture_counter.sv
// One PWM line: input synchronizer plus a windowed high-time counter whose
// clamped window total is held in a register until the next window ends.
module pwm_high_counter
    import motor_pwm_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_in,
    input  logic             wrap,
    output logic             line_sync,
    output logic [CMD_W-1:0] total
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CMD_W-1:0]       cnt_r;
    logic [CMD_W-1:0]       total_r;

    // Synchronizer chain for the asynchronous PWM line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], line_in};
        end
    end

    assign line_sync = sync_r[SYNC_STAGES-1];

    // The wrap cycle's own sample opens the next window, so no cycle is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (wrap) begin
            cnt_r <= {{(CMD_W-1){1'b0}}, line_sync};
        end else if (line_sync) begin
            cnt_r <= cnt_r + 11'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Snapshot the finished window before the counter restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_r <= '0;
        end else if (wrap) begin
            total_r <= clamp_mag(cnt_r);
        end else begin
            total_r <= total_r;
        end
    end

    assign total = total_r;

endmodule

// File: rtl/motor_pwm_capture.sv
// Reconstructs signed left/right duty commands from the four PWM drive lines
// and flags shoot-through (forward and reverse of one side high together).
module motor_pwm_capture
    import motor_pwm_pkg::*;
#(
    parameter int PERIOD      = PERIOD_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fwd_lft,
    input  logic              rev_lft,
    input  logic              fwd_rht,
    input  logic              rev_rht,
    input  logic              clr_err,
    output logic [CMD_W-1:0]  lft_meas,
    output logic [CMD_W-1:0]  rht_meas,
    output logic              meas_vld,
    output logic              shoot_lft,
    output logic              shoot_rht
);

    localparam int WIN_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PERIOD - 1);

    logic [WIN_W-1:0] win_r;
    logic             wrap_s;
    logic             calc_r;
    logic [CMD_W-1:0] tot_fl_s, tot_rl_s, tot_fr_s, tot_rr_s;
    logic             syn_fl_s, syn_rl_s, syn_fr_s, syn_rr_s;
    logic [CMD_W-1:0] lft_meas_r, rht_meas_r;
    logic             meas_vld_r;
    logic             shoot_lft_r, shoot_rht_r;

    assign wrap_s = (win_r == WIN_LAST);

    // Free-running window counter, deliberately unaligned to the PWM source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r <= '0;
        end else if (wrap_s) begin
            win_r <= '0;
        end else begin
            win_r <= win_r + WIN_W'(1);
        end
    end

    pwm_high_counter #(.SYNC_STAGES(SYNC_STAGES)) u_cnt_fl (
        .clk(clk), .rst_n(rst_n), .line_in(fwd_lft), .wrap(wrap_s),
        .line_sync(syn_fl_s), .total(tot_fl_s)
    );

    pwm_high_counter #(.SYNC_STAGES(SYNC_STAGES)) u_cnt_rl (
        .clk(clk), .rst_n(rst_n), .line_in(rev_lft), .wrap(wrap_s),
        .line_sync(syn_rl_s), .total(tot_rl_s)
    );

    pwm_high_counter #(.SYNC_STAGES(SYNC_STAGES)) u_cnt_fr (
        .clk(clk), .rst_n(rst_n), .line_in(fwd_rht), .wrap(wrap_s),
        .line_sync(syn_fr_s), .total(tot_fr_s)
    );

    pwm_high_counter #(.SYNC_STAGES(SYNC_STAGES)) u_cnt_rr (
        .clk(clk), .rst_n(rst_n), .line_in(rev_rht), .wrap(wrap_s),
        .line_sync(syn_rr_s), .total(tot_rr_s)
    );

    // Window totals land on the wrap edge; subtract them one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calc_r     <= 1'b0;
            meas_vld_r <= 1'b0;
            lft_meas_r <= '0;
            rht_meas_r <= '0;
        end else if (calc_r) begin
            calc_r     <= wrap_s;
            meas_vld_r <= 1'b1;
            lft_meas_r <= tot_fl_s - tot_rl_s;
            rht_meas_r <= tot_fr_s - tot_rr_s;
        end else begin
            calc_r     <= wrap_s;
            meas_vld_r <= 1'b0;
            lft_meas_r <= lft_meas_r;
            rht_meas_r <= rht_meas_r;
        end
    end

    // Sticky shoot-through flags; a fresh overlap beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shoot_lft_r <= 1'b0;
            shoot_rht_r <= 1'b0;
        end else begin
            if (syn_fl_s && syn_rl_s) begin
                shoot_lft_r <= 1'b1;
            end else if (clr_err) begin
                shoot_lft_r <= 1'b0;
            end else begin
                shoot_lft_r <= shoot_lft_r;
            end
            if (syn_fr_s && syn_rr_s) begin
                shoot_rht_r <= 1'b1;
            end else if (clr_err) begin
                shoot_rht_r <= 1'b0;
            end else begin
                shoot_rht_r <= shoot_rht_r;
            end
        end
    end

    assign lft_meas  = lft_meas_r;
    assign rht_meas  = rht_meas_r;
    assign meas_vld  = meas_vld_r;
    assign shoot_lft = shoot_lft_r;
    assign shoot_rht = shoot_rht_r;

endmodule

// File: tb/tb_motor_pwm_capture.sv
// Directed bench: a small PWM source model drives the capture block with
// known commands; captured values are compared against hand-computed results.
module tb_motor_pwm_capture;

    logic        clk;
    logic        rst_n;
    logic        fwd_lft, rev_lft, fwd_rht, rev_rht;
    logic        clr_err;
    logic [10:0] lft_meas, rht_meas;
    logic        meas_vld, shoot_lft, shoot_rht;

    int vec_cnt = 0;
    int err_cnt = 0;

    // PWM source state
    int lft_cmd = 0;
    int rht_cmd = 0;
    int pcnt    = 0;
    bit src_rst = 1'b1;
    bit frc_fl = 1'b0, frc_rl = 1'b0, frc_fr = 1'b0, frc_rr = 1'b0;

    typedef struct {
        int lft;
        int rht;
        int exp_l;
        int exp_r;
    } vec_t;

    vec_t tbl[5];

    motor_pwm_capture #(.PERIOD(1024), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fwd_lft  (fwd_lft),
        .rev_lft  (rev_lft),
        .fwd_rht  (fwd_rht),
        .rev_rht  (rev_rht),
        .clr_err  (clr_err),
        .lft_meas (lft_meas),
        .rht_meas (rht_meas),
        .meas_vld (meas_vld),
        .shoot_lft(shoot_lft),
        .shoot_rht(shoot_rht)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PWM source: lines change 2 ns after each rising edge, period 1024.
    initial begin
        fwd_lft = 1'b0; rev_lft = 1'b0; fwd_rht = 1'b0; rev_rht = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (src_rst) begin
                pcnt = 0;
                fwd_lft = 1'b0; rev_lft = 1'b0; fwd_rht = 1'b0; rev_rht = 1'b0;
            end else begin
                fwd_lft = frc_fl | (lft_cmd > 0 && pcnt <  lft_cmd);
                rev_lft = frc_rl | (lft_cmd < 0 && pcnt < -lft_cmd);
                fwd_rht = frc_fr | (rht_cmd > 0 && pcnt <  rht_cmd);
                rev_rht = frc_rr | (rht_cmd < 0 && pcnt < -rht_cmd);
                pcnt = (pcnt == 1023) ? 0 : pcnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (meas_vld !== 1'b1 && n < 3000);
        chk("meas_vld_seen", int'(meas_vld), 1);
    endtask

    initial begin
        int n;
        int v;

        tbl[0] = '{lft: 100,  rht: -102,  exp_l: 100,  exp_r: -102};
        tbl[1] = '{lft: 0,    rht: 0,     exp_l: 0,    exp_r: 0};
        tbl[2] = '{lft: -500, rht: 7,     exp_l: -500, exp_r: 7};
        tbl[3] = '{lft: 1,    rht: -1,    exp_l: 1,    exp_r: -1};
        tbl[4] = '{lft: 1023, rht: -1023, exp_l: 1023, exp_r: -1023};

        rst_n   = 1'b0;
        clr_err = 1'b0;
        repeat (3) tick();
        chk("rst_lft_meas",  int'($signed(lft_meas)), 0);
        chk("rst_rht_meas",  int'($signed(rht_meas)), 0);
        chk("rst_meas_vld",  int'(meas_vld), 0);
        chk("rst_shoot_lft", int'(shoot_lft), 0);
        chk("rst_shoot_rht", int'(shoot_rht), 0);

        rst_n   = 1'b1;
        src_rst = 1'b0;
        wait_vld(n);
        chk("first_vld_latency", n, 1025);
        chk("idle_lft", int'($signed(lft_meas)), 0);
        chk("idle_rht", int'($signed(rht_meas)), 0);
        tick();
        chk("vld_one_cycle", int'(meas_vld), 0);

        // Table: first pulse after a change may be blended, second is exact.
        for (int i = 0; i < 5; i++) begin
            lft_cmd = tbl[i].lft;
            rht_cmd = tbl[i].rht;
            wait_vld(n);
            wait_vld(n);
            chk("vld_period", n, 1024);
            chk("tbl_lft", int'($signed(lft_meas)), tbl[i].exp_l);
            chk("tbl_rht", int'($signed(rht_meas)), tbl[i].exp_r);
            chk("tbl_no_shoot", int'({shoot_lft, shoot_rht}), 0);
        end

        // Line held high for a whole window counts 1024 and must clamp.
        frc_fl = 1'b1;
        wait_vld(n);
        wait_vld(n);
        chk("clamp_lft", int'($signed(lft_meas)), 1023);
        chk("clamp_rht", int'($signed(rht_meas)), -1023);
        frc_fl = 1'b0;

        // Asynchronous reset mid-window, source restarted in phase.
        lft_cmd = 100;
        rht_cmd = -102;
        wait_vld(n);
        wait_vld(n);
        repeat (500) tick();
        #2;
        rst_n   = 1'b0;
        src_rst = 1'b1;
        #1;
        chk("async_rst_lft",  int'($signed(lft_meas)), 0);
        chk("async_rst_rht",  int'($signed(rht_meas)), 0);
        chk("async_rst_vld",  int'(meas_vld), 0);
        chk("async_rst_shoot", int'({shoot_lft, shoot_rht}), 0);
        repeat (3) tick();
        rst_n   = 1'b1;
        src_rst = 1'b0;
        wait_vld(n);
        chk("rst_vld_latency", n, 1025);
        chk("rst_first_lft", int'($signed(lft_meas)), 100);
        chk("rst_first_rht", int'($signed(rht_meas)), -102);

        // Command change mid-window: source phase puts this near pcnt 200.
        repeat (200) tick();
        lft_cmd = 300;
        wait_vld(n);
        v = int'($signed(lft_meas));
        chk("blend_in_range", int'(v > 100 && v < 300), 1);
        wait_vld(n);
        chk("blend_then_exact", int'($signed(lft_meas)), 300);

        // Shoot-through on the right side for three cycles.
        frc_fr = 1'b1;
        frc_rr = 1'b1;
        repeat (3) tick();
        frc_fr = 1'b0;
        frc_rr = 1'b0;
        repeat (5) tick();
        chk("shoot_rht_set", int'(shoot_rht), 1);
        chk("shoot_lft_clear", int'(shoot_lft), 0);
        repeat (20) tick();
        chk("shoot_rht_sticky", int'(shoot_rht), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("shoot_rht_cleared", int'(shoot_rht), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_when_clear", int'({shoot_lft, shoot_rht}), 0);

        // Last synchronized overlap cycle coincides with clr_err.
        frc_fr = 1'b1;
        frc_rr = 1'b1;
        repeat (3) tick();
        frc_fr = 1'b0;
        frc_rr = 1'b0;
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("set_beats_clear", int'(shoot_rht), 1);
        tick();
        chk("set_beats_clear_hold", int'(shoot_rht), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("final_clear", int'(shoot_rht), 0);
        chk("final_shoot_lft", int'(shoot_lft), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
